// File: rtl/cpu_pkg.sv
// Shared types for the ZhenCPU instruction-cycle sequencer:
// opcodes, the 8-phase state encoding and the control-strobe bundle.
package cpu_pkg;

  typedef enum logic [2:0] {
    OpHlt = 3'd0,
    OpSkz = 3'd1,
    OpAdd = 3'd2,
    OpAnd = 3'd3,
    OpXor = 3'd4,
    OpLda = 3'd5,
    OpSto = 3'd6,
    OpJmp = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    StInstAddr  = 3'd0,
    StInstFetch = 3'd1,
    StInstLoad  = 3'd2,
    StIdle      = 3'd3,
    StOpAddr    = 3'd4,
    StOpFetch   = 3'd5,
    StAluOp     = 3'd6,
    StStore     = 3'd7
  } phase_t;

  // halt here is the request to set the sticky flag, not the flag itself
  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic ld_pc;
    logic inc_pc;
    logic data_e;
    logic halt;
  } ctl_t;

  localparam ctl_t CtlNone = '0;

  function automatic logic is_aluop(opcode_t op);
    return (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// 8-phase fetch/execute sequencer: steps the phase register and decodes
// the current opcode into the strobes for PC, IR, accumulator and memory.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  phase_t  phase_q, phase_d;
  logic    halt_q, halt_d;
  ctl_t    dec;
  opcode_t op;
  logic    alu;
  logic    strobe_en;

  assign op  = opcode_t'(opcode);
  assign alu = is_aluop(op);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= StInstAddr;
      halt_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      halt_q  <= halt_d;
    end
  end

  // 7 -> 0 wrap is the plain 3-bit overflow
  always_comb begin
    phase_d = phase_q;
    halt_d  = halt_q;
    if (run && !halt_q) begin
      phase_d = phase_t'(phase_q + 3'd1);
      if (dec.halt) halt_d = 1'b1;
    end
  end

  always_comb begin
    dec = CtlNone;
    unique case (phase_q)
      StInstAddr: begin
        dec.sel = 1'b1;
      end
      StInstFetch: begin
        dec.sel = 1'b1;
        dec.rd  = 1'b1;
      end
      StInstLoad, StIdle: begin
        dec.sel   = 1'b1;
        dec.rd    = 1'b1;
        dec.ld_ir = 1'b1;
      end
      StOpAddr: begin
        dec.inc_pc = 1'b1;
        dec.halt   = (op == OpHlt);
      end
      StOpFetch: begin
        dec.rd = alu;
      end
      StAluOp: begin
        dec.rd     = alu;
        dec.ld_ac  = alu;
        dec.inc_pc = (op == OpSkz) && zero;
        dec.ld_pc  = (op == OpJmp);
        dec.data_e = (op == OpSto);
      end
      StStore: begin
        dec.rd     = alu;
        dec.ld_ac  = alu;
        // JMP raises both; the counter's load priority picks the load
        dec.inc_pc = (op == OpJmp);
        dec.ld_pc  = (op == OpJmp);
        dec.wr     = (op == OpSto);
        dec.data_e = (op == OpSto);
      end
      default: dec = CtlNone;
    endcase
  end

  // Pause, halt and reset all silence the strobes so nothing repeats.
  assign strobe_en = run && !halt_q && !rst;

  always_comb begin
    sel    = rst | (dec.sel & ~halt_q);
    rd     = dec.rd     & strobe_en;
    wr     = dec.wr     & strobe_en;
    ld_ir  = dec.ld_ir  & strobe_en;
    ld_ac  = dec.ld_ac  & strobe_en;
    ld_pc  = dec.ld_pc  & strobe_en;
    inc_pc = dec.inc_pc & strobe_en;
    data_e = dec.data_e & strobe_en;
    halt   = halt_q;
    phase  = phase_q;
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer with a 5-bit program counter model
// attached to the PC strobes (load data fixed at 19).
module tb_cpu_sequencer;

  logic       clk;
  logic       rst;
  logic       run;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
  logic [2:0] phase;

  logic [4:0] pc;

  typedef struct {
    logic [2:0] ph;
    logic [7:0] st;
    logic       h;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  cpu_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program counter: load has priority over increment.
  always @(posedge clk) begin
    if (rst) pc <= 5'd0;
    else if (ld_pc) pc <= 5'd19;
    else if (inc_pc) pc <= pc + 5'd1;
  end

  function automatic logic [7:0] strobes();
    return {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e};
  endfunction

  // Tasks start and end just after a falling edge.
  task automatic test_reset();
    rst = 1'b1; run = 1'b1; opcode = 3'd5; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++;
      if (phase !== 3'd0 || halt !== 1'b0 || strobes() !== 8'b1000_0000) begin
        bad++;
        $display("FAIL reset cyc%0d: got ph=%0d halt=%b st=%b want ph=0 halt=0 st=10000000",
                 i, phase, halt, strobes());
      end
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input int nph, input logic chk_pc, input logic [4:0] want_pc,
                           input logic [7:0] m_sel, input logic [7:0] m_rd,
                           input logic [7:0] m_wr, input logic [7:0] m_ir,
                           input logic [7:0] m_ac, input logic [7:0] m_ldpc,
                           input logic [7:0] m_inc, input logic [7:0] m_de);
    exp_t e;
    opcode = op; zero = z;
    #1;
    for (int p = 0; p < nph; p++) begin
      e.ph = 3'(p);
      e.st = {m_sel[p], m_rd[p], m_wr[p], m_ir[p], m_ac[p], m_ldpc[p], m_inc[p], m_de[p]};
      e.h  = 1'b0;
      sb.push_back(e);
    end
    for (int p = 0; p < nph; p++) begin
      e = sb.pop_front();
      total++;
      if (phase !== e.ph || strobes() !== e.st || halt !== e.h) begin
        bad++;
        $display("FAIL %s ph%0d: got ph=%0d st=%b halt=%b want ph=%0d st=%b halt=%b",
                 name, p, phase, strobes(), halt, e.ph, e.st, e.h);
      end
      @(negedge clk); #1;
    end
    if (nph == 8) begin
      total++;
      if (phase !== 3'd0) begin
        bad++;
        $display("FAIL %s wrap: got ph=%0d want ph=0", name, phase);
      end
    end
    if (chk_pc) begin
      total++;
      if (pc !== want_pc) begin
        bad++;
        $display("FAIL %s pc: got %0d want %0d", name, pc, want_pc);
      end
    end
  endtask

  task automatic test_lda();
    run_instr("lda", 3'd5, 1'b0, 8, 1'b1, pc + 5'd1, 8'h0F, 8'b1110_1110, 8'h00,
              8'b0000_1100, 8'b1100_0000, 8'h00, 8'b0001_0000, 8'h00);
    run_instr("add", 3'd2, 1'b1, 8, 1'b1, pc + 5'd1, 8'h0F, 8'b1110_1110, 8'h00,
              8'b0000_1100, 8'b1100_0000, 8'h00, 8'b0001_0000, 8'h00);
    run_instr("xor", 3'd4, 1'b0, 8, 1'b1, pc + 5'd1, 8'h0F, 8'b1110_1110, 8'h00,
              8'b0000_1100, 8'b1100_0000, 8'h00, 8'b0001_0000, 8'h00);
  endtask

  task automatic test_jmp();
    run_instr("jmp", 3'd7, 1'b0, 8, 1'b1, 5'd19, 8'h0F, 8'b0000_1110, 8'h00,
              8'b0000_1100, 8'h00, 8'b1100_0000, 8'b1001_0000, 8'h00);
  endtask

  task automatic test_skz();
    run_instr("skz_z1", 3'd1, 1'b1, 8, 1'b1, pc + 5'd2, 8'h0F, 8'b0000_1110, 8'h00,
              8'b0000_1100, 8'h00, 8'h00, 8'b0101_0000, 8'h00);
    run_instr("skz_z0", 3'd1, 1'b0, 8, 1'b1, pc + 5'd1, 8'h0F, 8'b0000_1110, 8'h00,
              8'b0000_1100, 8'h00, 8'h00, 8'b0001_0000, 8'h00);
  endtask

  task automatic test_sto();
    run_instr("sto", 3'd6, 1'b1, 8, 1'b1, pc + 5'd1, 8'h0F, 8'b0000_1110, 8'b1000_0000,
              8'b0000_1100, 8'h00, 8'h00, 8'b0001_0000, 8'b1100_0000);
  endtask

  task automatic test_halt();
    exp_t       e;
    logic [4:0] pc_hold;
    run_instr("hlt", 3'd0, 1'b0, 5, 1'b0, 5'd0, 8'h0F, 8'b0000_1110, 8'h00,
              8'b0000_1100, 8'h00, 8'h00, 8'b0001_0000, 8'h00);
    pc_hold = pc;
    opcode = 3'd7; zero = 1'b1;  // strobes must stay quiet whatever the opcode
    #1;
    for (int i = 0; i < 20; i++) begin
      e.ph = 3'd5; e.st = 8'h00; e.h = 1'b1;
      sb.push_back(e);
    end
    for (int i = 0; i < 20; i++) begin
      e = sb.pop_front();
      total++;
      if (phase !== e.ph || strobes() !== e.st || halt !== e.h) begin
        bad++;
        $display("FAIL halt_hold cyc%0d: got ph=%0d st=%b halt=%b want ph=%0d st=%b halt=%b",
                 i, phase, strobes(), halt, e.ph, e.st, e.h);
      end
      @(negedge clk); #1;
    end
    total++;
    if (pc !== pc_hold) begin
      bad++;
      $display("FAIL halt_pc: got %0d want %0d", pc, pc_hold);
    end
  endtask

  task automatic test_pause();
    exp_t e;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0; opcode = 3'd5; zero = 1'b0;
    #1;
    total++;
    if (phase !== 3'd0 || halt !== 1'b0) begin
      bad++;
      $display("FAIL rst_clears_halt: got ph=%0d halt=%b want ph=0 halt=0", phase, halt);
    end
    repeat (3) begin
      @(negedge clk); #1;
    end
    run = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      e.ph = 3'd3; e.st = 8'b1000_0000; e.h = 1'b0;
      sb.push_back(e);
    end
    for (int i = 0; i < 5; i++) begin
      e = sb.pop_front();
      total++;
      if (phase !== e.ph || strobes() !== e.st || halt !== e.h) begin
        bad++;
        $display("FAIL pause cyc%0d: got ph=%0d st=%b halt=%b want ph=%0d st=%b halt=%b",
                 i, phase, strobes(), halt, e.ph, e.st, e.h);
      end
      @(negedge clk); #1;
    end
    run = 1'b1;
    #1;
    total++;
    if (phase !== 3'd3 || strobes() !== 8'b1101_0000) begin
      bad++;
      $display("FAIL resume_ph3: got ph=%0d st=%b want ph=3 st=11010000", phase, strobes());
    end
    @(negedge clk); #1;
    total++;
    if (phase !== 3'd4 || strobes() !== 8'b0000_0010) begin
      bad++;
      $display("FAIL resume_ph4: got ph=%0d st=%b want ph=4 st=00000010", phase, strobes());
    end
    rst = 1'b1;
    #1;
    total++;
    if (phase !== 3'd4 || strobes() !== 8'b1000_0000) begin
      bad++;
      $display("FAIL midrst_strobes: got ph=%0d st=%b want ph=4 st=10000000", phase, strobes());
    end
    @(negedge clk); #1;
    total++;
    if (phase !== 3'd0 || halt !== 1'b0 || strobes() !== 8'b1000_0000) begin
      bad++;
      $display("FAIL midrst_phase: got ph=%0d halt=%b st=%b want ph=0 halt=0 st=10000000",
               phase, halt, strobes());
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_jmp", 3'd7, 1'b0, 8, 1'b1, 5'd19, 8'h0F, 8'b0000_1110, 8'h00,
              8'b0000_1100, 8'h00, 8'b1100_0000, 8'b1001_0000, 8'h00);
    run_instr("b2b_lda", 3'd5, 1'b0, 8, 1'b1, 5'd20, 8'h0F, 8'b1110_1110, 8'h00,
              8'b0000_1100, 8'b1100_0000, 8'h00, 8'b0001_0000, 8'h00);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; run = 1'b1; opcode = 3'd0; zero = 1'b0;
    test_reset();
    test_lda();
    test_jmp();
    test_skz();
    test_sto();
    test_halt();
    test_pause();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
